// File: rtl/station_pkg.sv
// Shared sizing helpers for the multi-engine ring station.
// Token width, FIFO depth and round-robin pointer width.
package station_pkg;

  localparam int STARVE_W = 8;

  function automatic int tok_width(input int pc_width);
    return pc_width + 1;
  endfunction

  function automatic int fifo_depth(input int count_width);
    return 1 << count_width;
  endfunction

  function automatic int ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin first-set search starting at ptr.
// Returns the winning index and its one-hot grant.
module rr_select
  import station_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] idx,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;

  // Rotate so bit 0 of rot is the request at ptr.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[N-1:0];

  always_comb begin
    found = 1'b0;
    idx   = '0;
    grant = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = int'(ptr) + k;
        if (pos >= N) pos = pos - N;
        idx   = PW'(pos);
        grant = N'(1) << pos;
      end
    end
  end

endmodule

// File: rtl/multi_engine_station.sv
// Ring station: delivers ring tokens to local engines and merges
// undeliverable tokens with engine output into a FIFO toward the ring.
module multi_engine_station
  import station_pkg::*;
#(
  parameter int NUM_ENGINES      = 4,
  parameter int PC_WIDTH         = 8,
  parameter int FIFO_COUNT_WIDTH = 6,
  parameter int STARVE_LIMIT     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ring_in_valid,
  output logic                                ring_in_ready,
  input  logic [PC_WIDTH:0]                   ring_in_data,
  output logic                                ring_out_valid,
  input  logic                                ring_out_ready,
  output logic [PC_WIDTH:0]                   ring_out_data,
  output logic [NUM_ENGINES-1:0]              eng_in_valid,
  input  logic [NUM_ENGINES-1:0]              eng_in_ready,
  output logic [NUM_ENGINES*(PC_WIDTH+1)-1:0] eng_in_data,
  input  logic [NUM_ENGINES-1:0]              eng_out_valid,
  output logic [NUM_ENGINES-1:0]              eng_out_ready,
  input  logic [NUM_ENGINES*(PC_WIDTH+1)-1:0] eng_out_data,
  input  logic [NUM_ENGINES-1:0]              engine_full,
  input  logic [NUM_ENGINES-1:0]              engine_running,
  output logic                                bb_full,
  output logic                                bb_running,
  output logic [FIFO_COUNT_WIDTH:0]           fifo_count
);

  localparam int N     = NUM_ENGINES;
  localparam int W     = tok_width(PC_WIDTH);
  localparam int CW    = FIFO_COUNT_WIDTH;
  localparam int DEPTH = fifo_depth(CW);
  localparam int PW    = ptr_width(N);
  localparam logic [STARVE_W-1:0] LIMIT =
    STARVE_W'(STARVE_LIMIT);

  logic [PW-1:0]       deliver_ptr;
  logic [PW-1:0]       collect_ptr;
  logic [PW-1:0]       d_idx;
  logic [PW-1:0]       c_idx;
  logic                d_found;
  logic                c_found;
  logic [N-1:0]        d_grant;
  logic [N-1:0]        c_grant;
  logic [STARVE_W-1:0] starve_cnt;

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW:0]   count;

  logic         full;
  logic         starved;
  logic         deliver;
  logic         ring_wr;
  logic         eng_wr;
  logic         push;
  logic         pop;
  logic [W-1:0] wr_data;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] i
  );
    return (i == PW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_select #(
    .N  (N),
    .PW (PW)
  ) u_deliver (
    .req   (eng_in_ready),
    .ptr   (deliver_ptr),
    .found (d_found),
    .idx   (d_idx),
    .grant (d_grant)
  );

  rr_select #(
    .N  (N),
    .PW (PW)
  ) u_collect (
    .req   (eng_out_valid),
    .ptr   (collect_ptr),
    .found (c_found),
    .idx   (c_idx),
    .grant (c_grant)
  );

  // Count MSB is set only at exactly DEPTH entries.
  assign full    = count[CW];
  assign starved = (starve_cnt == LIMIT);
  assign deliver = rst && ring_in_valid && d_found;

  // Ring traffic owns the FIFO port until engines have starved.
  assign ring_wr = rst && ring_in_valid && !d_found && !full
                && !(starved && c_found);
  assign eng_wr  = rst && c_found && !full && !ring_wr;

  assign push    = ring_wr || eng_wr;
  assign pop     = ring_out_valid && ring_out_ready;
  assign wr_data = ring_wr ? ring_in_data
                 : W'(eng_out_data >> (int'(c_idx) * W));

  assign ring_in_ready  = (rst && d_found) || ring_wr;
  assign eng_in_valid   = deliver ? d_grant : '0;
  assign eng_in_data    = {N{ring_in_data}};
  assign eng_out_ready  = eng_wr ? c_grant : '0;
  assign ring_out_valid = rst && (count != '0);
  assign ring_out_data  = mem[rd_ptr];
  assign fifo_count     = count;

  assign bb_full    = full && (&engine_full);
  assign bb_running = (count != '0) || (|engine_running)
                   || (|eng_out_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deliver_ptr <= '0;
      collect_ptr <= '0;
    end else begin
      if (deliver) deliver_ptr <= wrap_inc(d_idx);
      if (eng_wr)  collect_ptr <= wrap_inc(c_idx);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (eng_wr) begin
      starve_cnt <= '0;
    end else if ((|eng_out_valid) && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_multi_engine_station.sv
// Randomized and directed bench for multi_engine_station
// against a queue-based reference model.
module tb_multi_engine_station;

  localparam int N     = 4;
  localparam int PCW   = 8;
  localparam int CW    = 6;
  localparam int LIMIT = 8;
  localparam int W     = PCW + 1;
  localparam int DEPTH = 1 << CW;

  logic           clk = 1'b0;
  logic           rst;
  logic           ring_in_valid;
  logic           ring_in_ready;
  logic [W-1:0]   ring_in_data;
  logic           ring_out_valid;
  logic           ring_out_ready;
  logic [W-1:0]   ring_out_data;
  logic [N-1:0]   eng_in_valid;
  logic [N-1:0]   eng_in_ready;
  logic [N*W-1:0] eng_in_data;
  logic [N-1:0]   eng_out_valid;
  logic [N-1:0]   eng_out_ready;
  logic [N*W-1:0] eng_out_data;
  logic [N-1:0]   engine_full;
  logic [N-1:0]   engine_running;
  logic           bb_full;
  logic           bb_running;
  logic [CW:0]    fifo_count;

  multi_engine_station #(
    .NUM_ENGINES      (N),
    .PC_WIDTH         (PCW),
    .FIFO_COUNT_WIDTH (CW),
    .STARVE_LIMIT     (LIMIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ring_in_valid  (ring_in_valid),
    .ring_in_ready  (ring_in_ready),
    .ring_in_data   (ring_in_data),
    .ring_out_valid (ring_out_valid),
    .ring_out_ready (ring_out_ready),
    .ring_out_data  (ring_out_data),
    .eng_in_valid   (eng_in_valid),
    .eng_in_ready   (eng_in_ready),
    .eng_in_data    (eng_in_data),
    .eng_out_valid  (eng_out_valid),
    .eng_out_ready  (eng_out_ready),
    .eng_out_data   (eng_out_data),
    .engine_full    (engine_full),
    .engine_running (engine_running),
    .bb_full        (bb_full),
    .bb_running     (bb_running),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] m_q[$];
  int m_dptr;
  int m_cptr;
  int m_starve;

  int e_dsel;
  int e_csel;
  bit e_ring_wr;
  bit e_eng_wr;

  logic [N-1:0] x_eng_in_valid;
  logic [N-1:0] x_eng_out_ready;
  logic         x_ring_in_ready;
  logic         x_ring_out_valid;
  logic [W-1:0] x_ring_out_data;
  logic         x_bb_full;
  logic         x_bb_running;
  int           x_count;

  function automatic bit has(input logic [N-1:0] v, input int i);
    return ((v >> i) & N'(1)) != '0;
  endfunction

  function automatic logic [W-1:0] lane(
    input logic [N*W-1:0] v, input int i
  );
    return W'(v >> (i * W));
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_dptr   = 0;
    m_cptr   = 0;
    m_starve = 0;
  endtask

  task automatic model_eval();
    int j;
    e_dsel = -1;
    e_csel = -1;
    for (int k = 0; k < N; k++) begin
      j = (m_dptr + k) % N;
      if (e_dsel < 0 && has(eng_in_ready, j)) e_dsel = j;
      j = (m_cptr + k) % N;
      if (e_csel < 0 && has(eng_out_valid, j)) e_csel = j;
    end
    e_ring_wr = ring_in_valid && e_dsel < 0
             && m_q.size() < DEPTH
             && !(m_starve == LIMIT && e_csel >= 0);
    e_eng_wr  = e_csel >= 0 && m_q.size() < DEPTH && !e_ring_wr;
    x_eng_in_valid  = (ring_in_valid && e_dsel >= 0)
                    ? N'(1 << e_dsel) : '0;
    x_eng_out_ready = e_eng_wr ? N'(1 << e_csel) : '0;
    x_ring_in_ready = e_dsel >= 0 || e_ring_wr;
    x_count          = m_q.size();
    x_ring_out_valid = x_count != 0;
    x_ring_out_data  = (x_count != 0) ? m_q[0] : '0;
    x_bb_full    = x_count == DEPTH && engine_full == '1;
    x_bb_running = x_count != 0 || engine_running != '0
                || eng_out_valid != '0;
  endtask

  task automatic model_commit();
    model_eval();
    if (m_q.size() != 0 && ring_out_ready) void'(m_q.pop_front());
    if (e_ring_wr) m_q.push_back(ring_in_data);
    else if (e_eng_wr) m_q.push_back(lane(eng_out_data, e_csel));
    if (ring_in_valid && e_dsel >= 0) m_dptr = (e_dsel + 1) % N;
    if (e_eng_wr) begin
      m_cptr   = (e_csel + 1) % N;
      m_starve = 0;
    end else if (eng_out_valid != '0 && m_starve < LIMIT) begin
      m_starve++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_commit();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ring_in_valid  = 1'b0;
    ring_in_data   = '0;
    ring_out_ready = 1'b0;
    eng_in_ready   = '0;
    eng_out_valid  = '0;
    eng_out_data   = '0;
    engine_full    = '0;
    engine_running = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    ring_in_valid  = 1'b1;
    eng_in_ready   = '1;
    eng_out_valid  = '1;
    ring_out_ready = 1'b1;
    engine_full    = '1;
    #1;
    checks++;
    if (ring_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ring_in_ready: got %b want 0", ring_in_ready);
    end
    checks++;
    if (eng_in_valid !== '0) begin
      errors++;
      $display("FAIL rst_eng_in_valid: got %b want 0", eng_in_valid);
    end
    checks++;
    if (eng_out_ready !== '0) begin
      errors++;
      $display("FAIL rst_eng_out_ready: got %b want 0", eng_out_ready);
    end
    checks++;
    if (ring_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_ring_out_valid: got %b want 0", ring_out_valid);
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL rst_fifo_count: got %0d want 0", fifo_count);
    end
    checks++;
    if (bb_full !== 1'b0) begin
      errors++;
      $display("FAIL rst_bb_full: got %b want 0", bb_full);
    end
    idle_inputs();
    #1;
    checks++;
    if (bb_running !== 1'b0) begin
      errors++;
      $display("FAIL rst_bb_running: got %b want 0", bb_running);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_deliver();
    logic [W-1:0] tok;
    do_reset();
    eng_in_ready = '1;
    for (int i = 0; i < N; i++) begin
      tok           = W'($urandom);
      ring_in_valid = 1'b1;
      ring_in_data  = tok;
      #1;
      checks++;
      if (eng_in_valid !== N'(1 << i)) begin
        errors++;
        $display("FAIL deliver_valid[%0d]: got %b want %b",
                 i, eng_in_valid, N'(1 << i));
      end
      checks++;
      if (lane(eng_in_data, i) !== tok) begin
        errors++;
        $display("FAIL deliver_data[%0d]: got %h want %h",
                 i, lane(eng_in_data, i), tok);
      end
      checks++;
      if (ring_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL deliver_ready[%0d]: got %b want 1",
                 i, ring_in_ready);
      end
      tick();
    end
    ring_in_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== '0 || ring_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL deliver_fifo_empty: got count %0d valid %b want 0 0",
               fifo_count, ring_out_valid);
    end
  endtask

  task automatic test_fifo_single();
    do_reset();
    ring_in_valid = 1'b1;
    ring_in_data  = 9'h015;
    #1;
    checks++;
    if (ring_in_ready !== 1'b1 || ring_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_write_cycle: got ready %b out_valid %b want 1 0",
               ring_in_ready, ring_out_valid);
    end
    tick();
    ring_in_valid = 1'b0;
    #1;
    checks++;
    if (ring_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_out_valid: got %b want 1", ring_out_valid);
    end
    checks++;
    if (ring_out_data !== 9'h015) begin
      errors++;
      $display("FAIL single_out_data: got %h want 015", ring_out_data);
    end
    checks++;
    if (fifo_count !== 7'd1) begin
      errors++;
      $display("FAIL single_count: got %0d want 1", fifo_count);
    end
    checks++;
    if (bb_running !== 1'b1) begin
      errors++;
      $display("FAIL single_bb_running: got %b want 1", bb_running);
    end
    ring_out_ready = 1'b1;
    tick();
    ring_out_ready = 1'b0;
    #1;
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL single_drain: got %0d want 0", fifo_count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    engine_full = '1;
    for (int i = 0; i < DEPTH; i++) begin
      ring_in_valid = 1'b1;
      ring_in_data  = W'($urandom);
      #1;
      checks++;
      if (ring_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b want 1", i, ring_in_ready);
      end
      tick();
    end
    #1;
    checks++;
    if (fifo_count !== 7'(DEPTH)) begin
      errors++;
      $display("FAIL fill_count: got %0d want %0d", fifo_count, DEPTH);
    end
    checks++;
    if (ring_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full_ready: got %b want 0", ring_in_ready);
    end
    checks++;
    if (bb_full !== 1'b1) begin
      errors++;
      $display("FAIL fill_bb_full: got %b want 1", bb_full);
    end
    engine_full = 4'b0111;
    #1;
    checks++;
    if (bb_full !== 1'b0) begin
      errors++;
      $display("FAIL fill_bb_full_partial: got %b want 0", bb_full);
    end
    engine_full    = '1;
    ring_out_ready = 1'b1;
    #1;
    model_eval();
    checks++;
    if (ring_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_no_write: got %b want 0", ring_in_ready);
    end
    tick();
    ring_in_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 7'(DEPTH - 1)) begin
      errors++;
      $display("FAIL full_pop_count: got %0d want %0d",
               fifo_count, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      model_eval();
      checks++;
      if (ring_out_data !== x_ring_out_data) begin
        errors++;
        $display("FAIL drain_order[%0d]: got %h want %h",
                 i, ring_out_data, x_ring_out_data);
      end
      tick();
      #1;
    end
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL drain_count: got %0d want 0", fifo_count);
    end
    ring_out_ready = 1'b0;
  endtask

  task automatic test_starve();
    bit grant;
    do_reset();
    ring_out_ready = 1'b1;
    ring_in_valid  = 1'b1;
    eng_out_valid  = 4'b0100;
    for (int c = 1; c <= 2 * (LIMIT + 1) + 1; c++) begin
      ring_in_data = W'($urandom);
      eng_out_data = (N * W)'({$urandom, $urandom});
      #1;
      model_eval();
      grant = (c % (LIMIT + 1)) == 0;
      checks++;
      if (eng_out_ready !== (grant ? 4'b0100 : 4'b0000)) begin
        errors++;
        $display("FAIL starve_grant[c%0d]: got %b want %b",
                 c, eng_out_ready, grant ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (ring_in_ready !== !grant) begin
        errors++;
        $display("FAIL starve_ring_ready[c%0d]: got %b want %b",
                 c, ring_in_ready, !grant);
      end
      if (x_ring_out_valid) begin
        checks++;
        if (ring_out_data !== x_ring_out_data) begin
          errors++;
          $display("FAIL starve_out_data[c%0d]: got %h want %h",
                   c, ring_out_data, x_ring_out_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_simul();
    logic [W-1:0] toks [11];
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ring_in_valid = 1'b1;
      toks[i]       = W'($urandom);
      ring_in_data  = toks[i];
      tick();
    end
    toks[10]       = W'($urandom);
    ring_in_data   = toks[10];
    ring_out_ready = 1'b1;
    #1;
    checks++;
    if (ring_out_data !== toks[0]) begin
      errors++;
      $display("FAIL simul_pop_data: got %h want %h",
               ring_out_data, toks[0]);
    end
    checks++;
    if (ring_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_ready: got %b want 1", ring_in_ready);
    end
    tick();
    ring_in_valid  = 1'b0;
    ring_out_ready = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 7'd10) begin
      errors++;
      $display("FAIL simul_count: got %0d want 10", fifo_count);
    end
    checks++;
    if (ring_out_data !== toks[1]) begin
      errors++;
      $display("FAIL simul_next_head: got %h want %h",
               ring_out_data, toks[1]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ring_in_valid = 1'b1;
      ring_in_data  = W'($urandom);
      tick();
    end
    ring_in_valid = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 7'd5) begin
      errors++;
      $display("FAIL async_pre_count: got %0d want 5", fifo_count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (fifo_count !== '0) begin
      errors++;
      $display("FAIL async_count: got %0d want 0", fifo_count);
    end
    checks++;
    if (ring_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_out_valid: got %b want 0", ring_out_valid);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ring_in_valid  = $urandom_range(0, 3) != 0;
      ring_in_data   = W'($urandom);
      eng_in_ready   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      eng_out_valid  = N'($urandom) & N'($urandom);
      eng_out_data   = (N * W)'({$urandom, $urandom});
      ring_out_ready = ((cyc % 400) < 200)
                     ? ($urandom_range(0, 3) == 0)
                     : ($urandom_range(0, 3) != 0);
      engine_full    = N'($urandom) | N'($urandom);
      engine_running = N'($urandom) & N'($urandom) & N'($urandom);
      #1;
      model_eval();
      checks++;
      if (ring_in_ready !== x_ring_in_ready) begin
        errors++;
        $display("FAIL rnd_ring_in_ready[%0d]: got %b want %b",
                 cyc, ring_in_ready, x_ring_in_ready);
      end
      checks++;
      if (eng_in_valid !== x_eng_in_valid) begin
        errors++;
        $display("FAIL rnd_eng_in_valid[%0d]: got %b want %b",
                 cyc, eng_in_valid, x_eng_in_valid);
      end
      checks++;
      if (eng_out_ready !== x_eng_out_ready) begin
        errors++;
        $display("FAIL rnd_eng_out_ready[%0d]: got %b want %b",
                 cyc, eng_out_ready, x_eng_out_ready);
      end
      checks++;
      if (fifo_count !== 7'(x_count)) begin
        errors++;
        $display("FAIL rnd_fifo_count[%0d]: got %0d want %0d",
                 cyc, fifo_count, x_count);
      end
      checks++;
      if (ring_out_valid !== x_ring_out_valid) begin
        errors++;
        $display("FAIL rnd_ring_out_valid[%0d]: got %b want %b",
                 cyc, ring_out_valid, x_ring_out_valid);
      end
      if (x_ring_out_valid) begin
        checks++;
        if (ring_out_data !== x_ring_out_data) begin
          errors++;
          $display("FAIL rnd_ring_out_data[%0d]: got %h want %h",
                   cyc, ring_out_data, x_ring_out_data);
        end
      end
      if (e_dsel >= 0 && ring_in_valid) begin
        checks++;
        if (lane(eng_in_data, e_dsel) !== ring_in_data) begin
          errors++;
          $display("FAIL rnd_eng_in_data[%0d]: got %h want %h",
                   cyc, lane(eng_in_data, e_dsel), ring_in_data);
        end
      end
      checks++;
      if (bb_full !== x_bb_full) begin
        errors++;
        $display("FAIL rnd_bb_full[%0d]: got %b want %b",
                 cyc, bb_full, x_bb_full);
      end
      checks++;
      if (bb_running !== x_bb_running) begin
        errors++;
        $display("FAIL rnd_bb_running[%0d]: got %b want %b",
                 cyc, bb_running, x_bb_running);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_deliver();
    test_fifo_single();
    test_fill();
    test_starve();
    test_simul();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
